// File: rtl/fsk_dec_sched_if.sv
// fsk_dec_sched_if: operand/start/result bus of the shared BIN12_to_DEC4 converter
interface fsk_dec_sched_if;
   logic [11:0] conv_bin;
   logic        conv_st;
   logic [15:0] conv_dec;
   modport master (output conv_bin, conv_st, input conv_dec);
   modport slave  (input conv_bin, conv_st, output conv_dec);
endinterface

// File: rtl/fsk_dec_sched.sv
// fsk_dec_sched: time-shares one binary-to-BCD converter over the five FSK readouts
module fsk_dec_sched #(
   parameter int CONV_CYC    = 16,
   parameter int REFRESH_DIV = 50_000_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            trig,
   input  logic [11:0]     bin_amp,
   input  logic [12:0]     bin_sh,
   input  logic [11:0]     bin_f1,
   input  logic [11:0]     bin_f2,
   input  logic [11:0]     bin_amin,
   fsk_dec_sched_if.master conv,
   output logic [15:0]     amp_dec,
   output logic [15:0]     sh_dec,
   output logic [15:0]     f1_dec,
   output logic [15:0]     f2_dec,
   output logic [15:0]     amin_dec,
   output logic            sh_ovf,
   output logic            pic_st,
   output logic            sweep_done,
   output logic            busy
);
   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, STORE, CLRPK} state_t;
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int CW = $clog2(CONV_CYC + 1);
   state_t           state, state_n;
   logic [RW-1:0]    ref_cnt;
   logic [CW-1:0]    wait_cnt;
   logic [2:0]       idx;
   logic             pending, tick, req, start, snap_ovf;
   logic [4:0][11:0] snap;
   logic [4:0][15:0] dec;
   assign tick  = ref_cnt == RW'(REFRESH_DIV - 1);
   assign req   = trig | tick;
   assign start = state == IDLE && (req || pending);
   assign {amin_dec, f2_dec, f1_dec, sh_dec, amp_dec} = dec;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? LOAD : IDLE;
         LOAD:    state_n = START;
         START:   state_n = WAIT;
         WAIT:    state_n = wait_cnt == '0 ? STORE : WAIT;
         STORE:   state_n = idx == 3'd4 ? CLRPK : LOAD;
         default: state_n = IDLE;
      endcase
   end
   // snapshot is taken only when a sweep launches, so later input changes are ignored
   always_ff @(posedge clk)
      if (start) begin
         snap     <= {bin_amin, bin_f2, bin_f1, bin_sh[12] ? 12'hFFF : bin_sh[11:0], bin_amp};
         snap_ovf <= bin_sh[12];
      end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ref_cnt       <= '0;
         wait_cnt      <= '0;
         idx           <= '0;
         pending       <= 1'b0;
         dec           <= '0;
         sh_ovf        <= 1'b0;
         conv.conv_bin <= '0;
         conv.conv_st  <= 1'b0;
         pic_st        <= 1'b0;
         sweep_done    <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state   <= state_n;
         ref_cnt <= tick ? '0 : ref_cnt + 1'b1;
         pending <= state == IDLE ? 1'b0 : pending | req;
         if (state == LOAD) conv.conv_bin <= snap[idx];
         if (state == START) wait_cnt <= CW'(CONV_CYC - 1);
         if (state == WAIT) wait_cnt <= wait_cnt - 1'b1;
         if (state == STORE) begin
            dec[idx] <= conv.conv_dec;
            idx      <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
            if (idx == 3'd1) sh_ovf <= snap_ovf;
         end
         if (state == CLRPK) idx <= '0;
         // strobes are registered from the next state so they coincide with it
         conv.conv_st <= state_n == START;
         pic_st       <= state_n == CLRPK;
         sweep_done   <= state_n == CLRPK;
         busy         <= state_n != IDLE;
      end
   end
endmodule
